// File: rtl/pmod_spi_responder.sv
// SPI mode-0 responder for the Pmod top row: oversamples SS/SCK/MOSI on clk, valid/ready byte ports.
// Define PMOD_SPI_RESPONDER_SYNC2_EN for a two-flop pin synchronizer (asynchronous master).
module pmod_spi_responder #(
    parameter logic [7:0] FILL_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ss_i,
    input  logic       sck_i,
    input  logic       io0_i,
    output logic       io1_o,
    output logic       io1_t,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       overrun,
    output logic       frame_abort,
    output logic [1:0] state_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    // Pin sampling keeps running through reset so the edge detector never sees a false SS fall.
    logic [2:0] sync_q;
    logic [1:0] prev_q;
`ifdef PMOD_SPI_RESPONDER_SYNC2_EN
    logic [2:0] meta_q;
    always_ff @(posedge clk) begin
        meta_q <= {ss_i, sck_i, io0_i};
        sync_q <= meta_q;
        prev_q <= sync_q[2:1];
    end
`else
    always_ff @(posedge clk) begin
        sync_q <= {ss_i, sck_i, io0_i};
        prev_q <= sync_q[2:1];
    end
`endif

    logic ss_n, sck_s, mosi_s, ss_prev, sck_prev, sck_r, sck_f;
    assign ss_n     = sync_q[2];
    assign sck_s    = sync_q[1];
    assign mosi_s   = sync_q[0];
    assign ss_prev  = prev_q[1];
    assign sck_prev = prev_q[0];
    assign sck_r    = sck_s & ~sck_prev;
    assign sck_f    = ~sck_s & sck_prev;

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic       io1_q, io1_d;
    logic       io1_t_q, io1_t_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       overrun_q, overrun_d;
    logic       abort_q, abort_d;
    logic       load_evt;
    logic [7:0] load_byte;
    logic [7:0] rx_byte;

    assign load_byte = tx_valid ? tx_data : FILL_BYTE;
    assign rx_byte   = {rx_sh_q[6:0], mosi_s};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        io1_d      = io1_q;
        io1_t_d    = io1_t_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q & ~rx_ready;
        overrun_d  = 1'b0;
        abort_d    = 1'b0;
        load_evt   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                io1_t_d = 1'b1;
                // Low SS without a seen fall means we came up mid-frame.
                if (!ss_n) begin
                    if (ss_prev) begin
                        load_evt = 1'b1;
                        tx_sh_d  = load_byte;
                        io1_d    = load_byte[7];
                        io1_t_d  = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = ST_SHIFT;
                    end else begin
                        state_d = ST_ABORT;
                    end
                end
            end
            ST_SHIFT: begin
                if (ss_n) begin
                    io1_t_d = 1'b1;
                    state_d = ST_IDLE;
                    abort_d = (cnt_q >= 4'd1) && (cnt_q <= 4'd7);
                end else if (sck_r) begin
                    rx_sh_d = rx_byte;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        if (!rx_valid_q || rx_ready) begin
                            rx_data_d  = rx_byte;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end else if (sck_f) begin
                    if (cnt_q == 4'd8) begin
                        load_evt = 1'b1;
                        tx_sh_d  = load_byte;
                        io1_d    = load_byte[7];
                        cnt_d    = 4'd0;
                    end else if (cnt_q != 4'd0) begin
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                        io1_d   = tx_sh_q[6];
                    end
                end
            end
            default: begin
                io1_t_d = 1'b1;
                if (ss_n) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            rx_sh_q    <= 8'h00;
            tx_sh_q    <= 8'h00;
            io1_q      <= 1'b1;
            io1_t_q    <= 1'b1;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_sh_q    <= rx_sh_d;
            tx_sh_q    <= tx_sh_d;
            io1_q      <= io1_d;
            io1_t_q    <= io1_t_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            abort_q    <= abort_d;
        end
    end

    // tx_ready is combinational so the producer sees the transfer in the cycle it happens.
    assign tx_ready    = load_evt & tx_valid & ~reset;
    assign io1_o       = io1_q;
    assign io1_t       = io1_t_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign overrun     = overrun_q;
    assign frame_abort = abort_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pmod_spi_responder.sv
// Directed bench for pmod_spi_responder: bit-banged mode-0 master, tx producer, rx/pulse monitors.
module tb_pmod_spi_responder;

    logic       clk, reset, ss, sck, io0;
    logic       io1_o, io1_t;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, overrun, frame_abort;
    logic [1:0] state_o;

    pmod_spi_responder dut (
        .clk(clk), .reset(reset), .ss_i(ss), .sck_i(sck), .io0_i(io0),
        .io1_o(io1_o), .io1_t(io1_t), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .overrun(overrun), .frame_abort(frame_abort),
        .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int txr_cnt = 0;
    int ovr_cnt = 0;
    int abt_cnt = 0;
    int t_low   = 0;
    logic mon_t = 1'b0;
    logic hs;
    logic [7:0] tx_src[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic       tv;
        logic [7:0] td;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        int         exp_txr;
    } vec_t;
    vec_t vecs[5];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic m, output logic s);
        io0 = m;
        tick(8);
        s = io1_o;
        sck = 1'b1;
        tick(8);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] m, output logic [7:0] s);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(m[i], b);
            s[i] = b;
        end
    endtask

    task automatic frame_begin();
        ss = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        tick(4);
        ss = 1'b1;
        tick(10);
    endtask

    task automatic check_rx_stream(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check({name, "_byte"}, got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Pulse and rx monitors sample on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (overrun) ovr_cnt++;
        if (frame_abort) abt_cnt++;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (mon_t && !io1_t) t_low++;
    end

    // Producer: offers tx_src[0] until the handshake, then moves on.
    initial begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            hs = tx_valid && tx_ready;
            if (hs) txr_cnt++;
            @(posedge clk);
            #1;
            if (hs && tx_src.size() > 0) void'(tx_src.pop_front());
            tx_valid = (tx_src.size() > 0);
            tx_data  = tx_valid ? tx_src[0] : 8'h00;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s, s2;
        logic b;
        int t0, o0, a0;

        vecs[0] = '{tv: 1'b1, td: 8'hA5, mosi: 8'h3C, exp_miso: 8'hA5, exp_txr: 1};
        vecs[1] = '{tv: 1'b0, td: 8'h00, mosi: 8'h5A, exp_miso: 8'hFF, exp_txr: 0};
        vecs[2] = '{tv: 1'b1, td: 8'h00, mosi: 8'hFF, exp_miso: 8'h00, exp_txr: 1};
        vecs[3] = '{tv: 1'b1, td: 8'h80, mosi: 8'h01, exp_miso: 8'h80, exp_txr: 1};
        vecs[4] = '{tv: 1'b1, td: 8'h7E, mosi: 8'h81, exp_miso: 8'h7E, exp_txr: 1};

        reset = 1'b1; ss = 1'b1; sck = 1'b0; io0 = 1'b0; rx_ready = 1'b0;
        tick(5);
        check("rst_io1_o", io1_o, 1'b1);
        check("rst_io1_t", io1_t, 1'b1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_abort", frame_abort, 1'b0);
        check("rst_state", state_o, 2'd0);
        reset = 1'b0;
        tick(3);

        // Single-byte loopback vectors; rx held unconsumed so rx_valid/rx_data can be inspected.
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].tv) tx_src.push_back(vecs[v].td);
            tick(2);
            t0 = txr_cnt;
            rx_ready = 1'b0;
            frame_begin();
            check("vec_io1_t_active", io1_t, 1'b0);
            spi_byte(vecs[v].mosi, s);
            frame_end();
            check("vec_miso", s, vecs[v].exp_miso);
            check("vec_rx_data", rx_data, vecs[v].mosi);
            check("vec_rx_valid", rx_valid, 1'b1);
            check("vec_tx_ready_pulses", txr_cnt - t0, vecs[v].exp_txr);
            check("vec_io1_t_idle", io1_t, 1'b1);
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
            check("vec_rx_consumed", rx_valid, 1'b0);
            got_q.delete();
        end

        // Empty transmit, 2-byte frame.
        rx_ready = 1'b1;
        got_q.delete();
        frame_begin();
        spi_byte(8'h55, s);
        spi_byte(8'hAA, s2);
        frame_end();
        check("empty_miso0", s, 8'hFF);
        check("empty_miso1", s2, 8'hFF);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        check_rx_stream("empty_rx");

        // Overrun: consumer stalled across two bytes.
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        frame_begin();
        spi_byte(8'h11, s);
        check("ovr_none_after_b1", ovr_cnt - o0, 0);
        spi_byte(8'h22, s);
        frame_end();
        check("ovr_pulses", ovr_cnt - o0, 1);
        check("ovr_rx_data", rx_data, 8'h11);
        check("ovr_rx_valid", rx_valid, 1'b1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        got_q.delete();

        // Abort after 5 rising edges.
        a0 = abt_cnt;
        frame_begin();
        for (int i = 0; i < 5; i++) spi_bit(i[0], b);
        tick(4);
        ss = 1'b1;
        tick(3);
        check("abort_io1_t", io1_t, 1'b1);
        tick(5);
        check("abort_pulses", abt_cnt - a0, 1);
        check("abort_rx_valid", rx_valid, 1'b0);
        check("abort_state", state_o, 2'd0);

        // Reset during bit 3 with SS held low.
        rx_ready = 1'b1;
        got_q.delete();
        t0 = txr_cnt;
        frame_begin();
        spi_bit(1'b1, b);
        spi_bit(1'b0, b);
        io0 = 1'b1;
        tick(8);
        sck = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(1);
        mon_t = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(4);
        check("rstmid_state_abort", state_o, 2'd2);
        sck = 1'b0;
        for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
        spi_byte(8'h96, s);
        spi_byte(8'h69, s);
        tick(4);
        ss = 1'b1;
        tick(10);
        mon_t = 1'b0;
        check("rstmid_io1_t_low_cycles", t_low, 0);
        check("rstmid_rx_bytes", got_q.size(), 0);
        check("rstmid_tx_ready", txr_cnt - t0, 0);
        check("rstmid_state_idle", state_o, 2'd0);
        tx_src.push_back(8'h5A);
        tick(2);
        frame_begin();
        spi_byte(8'hC3, s);
        frame_end();
        check("rstmid_next_miso", s, 8'h5A);
        exp_q.push_back(8'hC3);
        check_rx_stream("rstmid_next_rx");

        // Back-to-back 4-byte frame with a queued producer.
        for (int i = 1; i <= 4; i++) tx_src.push_back(i[7:0]);
        tick(2);
        t0 = txr_cnt;
        frame_begin();
        for (int i = 1; i <= 4; i++) begin
            spi_byte(8'hC0 + i[7:0], s);
            check("b2b_miso", s, i[7:0]);
            exp_q.push_back(8'hC0 + i[7:0]);
        end
        frame_end();
        check("b2b_tx_ready_pulses", txr_cnt - t0, 4);
        check_rx_stream("b2b_rx");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
